fir_xifu_ex: RTL and testbench
==============================

// Module: fir_xifu_ex
// PURPOSE
//  - Execute stage of the FIR XIFU coprocessor, directly downstream of the ID stage; consumes the registered id2ex record.
//  - XFIRLW: base+offset address, XIF memory load, loaded word written to XIFU reg rd.
//  - XFIRSW: XIFU reg rs2 stored to memory.
//  - XFIRDOTP: 2-lane int16 dot-product accumulated into XIFU reg rd.
//  - Results go to the XIFU register file via ex2wb_o; stalls ID through ex_ready_o.
// PARAMETERS
//  XLEN        32  data/address width
//  NB_XREGS    32  XIFU register file depth (index width $clog2(NB_XREGS))
//  ID_WIDTH    4   XIF instruction id width
// PORTS
//  clk_i             in   1        clock
//  rst_ni            in   1        reset; synchronous, active-low
//  id2ex_i           in   struct   fir_xifu_id2ex_t {instr, base, offset[11:0], rs1, rs2, rd, id}
//  id2ex_valid_i     in   1        id2ex_i holds a new instruction
//  ex_ready_o        out  1        EX can accept id2ex_i this cycle
//  ctrl2ex_i         in   struct   fir_xifu_ctrl2ex_t {xrs1_data, xrs2_data, xrd_data}, XLEN each
//  xif_mem_o         mp   -        cv32e40x_if_xif.coproc_mem (mem_valid/ready, mem_req.{addr,we,be,wdata,id})
//  xif_mem_result_i  mp   -        cv32e40x_if_xif.coproc_mem_result (mem_result_valid, mem_result.rdata)
//  ex2wb_o           out  struct   fir_xifu_ex2wb_t {we, rd, data[XLEN-1:0]}
//  ex2ctrl_o         out  struct   fir_xifu_ex2ctrl_t {busy, misaligned, done, id}
// BEHAVIOUR
//  - Reset values: all outputs 0, except ex_ready_o=1 (IDLE); state=IDLE; operand latches cleared.
//  - Accept: id2ex_valid_i & ex_ready_o. On accept, latch id2ex_i and ctrl2ex_i.
//  - FSM IDLE -> REQ | DOTP | IDLE(misaligned).
//    - IDLE: ex_ready_o=1.
//      - Accept LW/SW with addr[1:0]==0 -> REQ.
//      - Accept DOTP -> DOTP.
//      - Accept LW/SW with addr[1:0]!=0 -> no mem request; misaligned=1 and done=1 for 1 cycle; stay IDLE.
//    - REQ: mem_valid=1; addr=base+sext(offset) mod 2^XLEN; be=4'hF; we=(SW); wdata=xrs2 (SW) else 0; id=latched id.
//      - Request stable until mem_ready; mem_ready -> RESP.
//    - RESP: wait for mem_result_valid.
//      - LW -> WB with rdata latched.
//      - SW -> IDLE, done=1.
//    - WB: ex2wb_o.we=1, rd=latched rd, data=rdata, 1 cycle -> IDLE, done=1.
//    - DOTP: 1 cycle; ex2wb_o.we=1, rd=latched rd, data=xrd + a0*b0 + a1*b1 (int16 lanes, sext to 32) -> IDLE, done=1.
//  - ex_ready_o=0 in all states except IDLE; busy=~(state==IDLE).
//  - Latency accept->writeback:
//    - DOTP: 1 cycle.
//    - LW: 2 + mem_ready wait + result wait.
//  - mem_ready and mem_result_valid in the same cycle as REQ: ignore the result; result is only sampled in RESP.
//  - ex2wb_o and done are single-cycle pulses, combinational from state, zero otherwise.
//  - Reset mid-transaction: return to IDLE next edge, mem_valid drops, outstanding result ignored.
//  - INSTR_INVALID accepted: dropped silently, stay IDLE.
// CONFIGURATION
//  - FIR_XIFU_DOTP_SAT_EN defined:
//    - DOTP sum computed in 34 bits.
//    - Result saturated to [0x8000_0000, 0x7FFF_FFFF].
//  - Undefined: result wraps mod 2^32.
// STRUCTURE
//  - fir_xifu_pkg holds:
//    - fir_xifu_ex2wb_t, fir_xifu_ctrl2ex_t, fir_xifu_ex2ctrl_t
//    - fir_xifu_ex_state_e {EX_IDLE, EX_REQ, EX_RESP, EX_WB, EX_DOTP}
//    - XIFU_MEM_BE_WORD constant
//  - Sub-module fir_xifu_dotp: combinational 2x16b MAC (+ optional saturation).
// TESTING
//  - DOTP: xrs1=0x0003_FFFE, xrs2=0x0002_0005, xrd=10
//    -> wb data=10+(-2*5)+(3*2)=6, rd matches, 1 cycle after accept.
//  - LW: base=0x1000, offset=-4
//    -> mem addr=0x0FFC, we=0; mem_ready after 3 cycles; rdata=0xCAFEBABE -> wb we=1, data=0xCAFEBABE.
//  - SW: base=0x2000, offset=8, xrs2=0x1234_5678
//    -> addr=0x2008, we=1, be=4'hF, wdata=0x1234_5678; no ex2wb write; done on result.
//  - Misaligned LW: base=0x1001
//    -> no mem_valid; misaligned=1 and done=1 for one cycle; ex_ready_o stays 1.
//  - Back-pressure:
//    - id2ex_valid_i held high during LW wait -> ex_ready_o=0; second instruction accepted only in IDLE.
//    - Reset asserted in RESP -> IDLE, outputs zero.
//  - SAT: xrs1=xrs2=0x8000_8000, xrd=0x7FFF_FFFF
//    -> 0x7FFF_FFFF with FIR_XIFU_DOTP_SAT_EN; wrapped 0x7FFF_FFFF+0x8000_0000=0xFFFF_FFFF without.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_pkg
// Description : Shared types and constants for the FIR XIFU coprocessor
//               (inter-stage records, EX state encoding, address helper).
// Revision    : 1.0 - initial release
// ============================================================================
package fir_xifu_pkg;

    localparam int XLEN       = 32;
    localparam int NB_XREGS   = 32;
    localparam int ID_WIDTH   = 4;
    localparam int XREG_IDX_W = $clog2(NB_XREGS);

    // All XIFU memory accesses are full aligned words
    localparam logic [3:0] XIFU_MEM_BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        INSTR_INVALID  = 2'd0,
        INSTR_XFIRLW   = 2'd1,
        INSTR_XFIRSW   = 2'd2,
        INSTR_XFIRDOTP = 2'd3
    } fir_xifu_instr_e;

    typedef struct packed {
        fir_xifu_instr_e         instr;
        logic [XLEN-1:0]         base;
        logic [11:0]             offset;
        logic [XREG_IDX_W-1:0]   rs1;
        logic [XREG_IDX_W-1:0]   rs2;
        logic [XREG_IDX_W-1:0]   rd;
        logic [ID_WIDTH-1:0]     id;
    } fir_xifu_id2ex_t;

    typedef struct packed {
        logic [XLEN-1:0] xrs1_data;
        logic [XLEN-1:0] xrs2_data;
        logic [XLEN-1:0] xrd_data;
    } fir_xifu_ctrl2ex_t;

    typedef struct packed {
        logic                  we;
        logic [XREG_IDX_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic                busy;
        logic                misaligned;
        logic                done;
        logic [ID_WIDTH-1:0] id;
    } fir_xifu_ex2ctrl_t;

    typedef enum logic [2:0] {
        EX_IDLE = 3'd0,
        EX_REQ  = 3'd1,
        EX_RESP = 3'd2,
        EX_WB   = 3'd3,
        EX_DOTP = 3'd4
    } fir_xifu_ex_state_e;

    // Effective address: base plus sign-extended 12-bit offset, wrapping
    function automatic logic [XLEN-1:0] xifu_agen(input logic [XLEN-1:0] base,
                                                  input logic [11:0]     offset);
        return base + {{(XLEN-12){offset[11]}}, offset};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_xifu_dotp.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_dotp
// Description : Combinational 2-lane int16 dot-product accumulate:
//               res = acc + a0*b0 + a1*b1 (lane 0 = bits 15:0).
//               FIR_XIFU_DOTP_SAT_EN defined : saturate to signed 32 bits.
//               FIR_XIFU_DOTP_SAT_EN undefined: wrap modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_dotp
    import fir_xifu_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_acc,
    output logic [XLEN-1:0] o_res
);

    logic signed [31:0] w_a0;
    logic signed [31:0] w_a1;
    logic signed [31:0] w_b0;
    logic signed [31:0] w_b1;
    logic signed [31:0] w_p0;
    logic signed [31:0] w_p1;

    // Each int16 x int16 product fits in 32 signed bits (worst case 2^30)
    assign w_a0 = {{16{i_a[15]}}, i_a[15:0]};
    assign w_a1 = {{16{i_a[31]}}, i_a[31:16]};
    assign w_b0 = {{16{i_b[15]}}, i_b[15:0]};
    assign w_b1 = {{16{i_b[31]}}, i_b[31:16]};
    assign w_p0 = w_a0 * w_b0;
    assign w_p1 = w_a1 * w_b1;

`ifdef FIR_XIFU_DOTP_SAT_EN
    localparam logic signed [33:0] c_SAT_MAX = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] c_SAT_MIN = -34'sh0_8000_0000;

    logic signed [33:0] w_sum;

    // 34 bits hold acc + two products without overflow
    assign w_sum = {{2{i_acc[31]}}, i_acc} + {{2{w_p0[31]}}, w_p0} + {{2{w_p1[31]}}, w_p1};

    // Clamp the wide sum into the signed 32-bit range
    always_comb begin
        if (w_sum > c_SAT_MAX) begin
            o_res = 32'h7FFF_FFFF;
        end else if (w_sum < c_SAT_MIN) begin
            o_res = 32'h8000_0000;
        end else begin
            o_res = w_sum[31:0];
        end
    end
`else
    // Plain modulo-2^32 accumulate
    always_comb begin
        o_res = i_acc + w_p0 + w_p1;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/fir_xifu_ex.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_ex
// Description : Execute stage of the FIR XIFU coprocessor. Runs XFIRLW /
//               XFIRSW through the XIF memory interface and XFIRDOTP through
//               fir_xifu_dotp; results leave on ex2wb_o as one-cycle pulses.
//               Optional build macro: FIR_XIFU_DOTP_SAT_EN (saturating DOTP).
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_ex
    import fir_xifu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  fir_xifu_id2ex_t     id2ex_i,
    input  logic                id2ex_valid_i,
    output logic                ex_ready_o,
    input  fir_xifu_ctrl2ex_t   ctrl2ex_i,
    output logic                xif_mem_valid_o,
    input  logic                xif_mem_ready_i,
    output logic [XLEN-1:0]     xif_mem_addr_o,
    output logic                xif_mem_we_o,
    output logic [3:0]          xif_mem_be_o,
    output logic [XLEN-1:0]     xif_mem_wdata_o,
    output logic [ID_WIDTH-1:0] xif_mem_id_o,
    input  logic                xif_mem_result_valid_i,
    input  logic [XLEN-1:0]     xif_mem_result_rdata_i,
    output fir_xifu_ex2wb_t     ex2wb_o,
    output fir_xifu_ex2ctrl_t   ex2ctrl_o
);

    fir_xifu_ex_state_e r_state;
    fir_xifu_ex_state_e w_state_nxt;
    fir_xifu_id2ex_t    r_id2ex;
    fir_xifu_ctrl2ex_t  r_ctrl2ex;
    logic [XLEN-1:0]    r_rdata;
    logic               r_misaligned;

    logic               w_accept;
    logic               w_in_is_mem;
    logic [1:0]         w_in_addr_lsb;
    logic               w_in_misaligned;
    logic [XLEN-1:0]    w_addr;
    logic [XLEN-1:0]    w_dotp_res;
    logic               w_is_sw;
    logic               w_unused;

    assign w_accept        = id2ex_valid_i & ex_ready_o;
    assign w_in_is_mem     = (id2ex_i.instr == INSTR_XFIRLW) || (id2ex_i.instr == INSTR_XFIRSW);
    // Only the low two address bits decide alignment
    assign w_in_addr_lsb   = id2ex_i.base[1:0] + id2ex_i.offset[1:0];
    assign w_in_misaligned = w_in_is_mem && (w_in_addr_lsb != 2'b00);
    assign w_addr          = xifu_agen(r_id2ex.base, r_id2ex.offset);
    assign w_is_sw         = (r_id2ex.instr == INSTR_XFIRSW);
    // Source indices travel with the record but operands arrive via ctrl2ex
    assign w_unused        = ^{r_id2ex.rs1, r_id2ex.rs2};

    fir_xifu_dotp u_dotp (
        .i_a   (r_ctrl2ex.xrs1_data),
        .i_b   (r_ctrl2ex.xrs2_data),
        .i_acc (r_ctrl2ex.xrd_data),
        .o_res (w_dotp_res)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= EX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latches, load data capture and the misaligned flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id2ex      <= '0;
            r_ctrl2ex    <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_in_misaligned;
            if (w_accept) begin
                r_id2ex   <= id2ex_i;
                r_ctrl2ex <= ctrl2ex_i;
            end
            if ((r_state == EX_RESP) && xif_mem_result_valid_i) begin
                r_rdata <= xif_mem_result_rdata_i;
            end
        end
    end

    // Next-state logic; a result seen while still in REQ is deliberately ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EX_IDLE: begin
                if (w_accept) begin
                    case (id2ex_i.instr)
                        INSTR_XFIRLW,
                        INSTR_XFIRSW:   w_state_nxt = w_in_misaligned ? EX_IDLE : EX_REQ;
                        INSTR_XFIRDOTP: w_state_nxt = EX_DOTP;
                        default:        w_state_nxt = EX_IDLE;
                    endcase
                end
            end
            EX_REQ: begin
                if (xif_mem_ready_i) begin
                    w_state_nxt = EX_RESP;
                end
            end
            EX_RESP: begin
                if (xif_mem_result_valid_i) begin
                    w_state_nxt = w_is_sw ? EX_IDLE : EX_WB;
                end
            end
            EX_WB:   w_state_nxt = EX_IDLE;
            EX_DOTP: w_state_nxt = EX_IDLE;
            default: w_state_nxt = EX_IDLE;
        endcase
    end

    // Outputs decoded from state; everything is zero outside its owning state
    always_comb begin
        ex_ready_o      = (r_state == EX_IDLE);
        xif_mem_valid_o = 1'b0;
        xif_mem_addr_o  = '0;
        xif_mem_we_o    = 1'b0;
        xif_mem_be_o    = 4'h0;
        xif_mem_wdata_o = '0;
        xif_mem_id_o    = '0;
        ex2wb_o         = '0;
        ex2ctrl_o       = '0;
        ex2ctrl_o.busy       = (r_state != EX_IDLE);
        ex2ctrl_o.misaligned = r_misaligned;
        ex2ctrl_o.id         = r_id2ex.id;
        ex2ctrl_o.done       = r_misaligned;
        case (r_state)
            EX_REQ: begin
                xif_mem_valid_o = 1'b1;
                xif_mem_addr_o  = w_addr;
                xif_mem_we_o    = w_is_sw;
                xif_mem_be_o    = XIFU_MEM_BE_WORD;
                xif_mem_wdata_o = w_is_sw ? r_ctrl2ex.xrs2_data : '0;
                xif_mem_id_o    = r_id2ex.id;
            end
            EX_RESP: begin
                ex2ctrl_o.done = w_is_sw && xif_mem_result_valid_i;
            end
            EX_WB: begin
                ex2wb_o.we     = 1'b1;
                ex2wb_o.rd     = r_id2ex.rd;
                ex2wb_o.data   = r_rdata;
                ex2ctrl_o.done = 1'b1;
            end
            EX_DOTP: begin
                ex2wb_o.we     = 1'b1;
                ex2wb_o.rd     = r_id2ex.rd;
                ex2wb_o.data   = w_dotp_res;
                ex2ctrl_o.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ex.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_xifu_ex
// Description : Scoreboard bench for fir_xifu_ex: directed vectors, a reset
//               in RESP, then randomized LW/SW/DOTP/INVALID traffic against a
//               word-addressed memory model and an integer DOTP model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    fir_xifu_id2ex_t   id2ex;
    logic              id2ex_valid;
    logic              ex_ready;
    fir_xifu_ctrl2ex_t ctrl2ex;
    logic              mem_valid, mem_ready, mem_we, res_valid;
    logic [31:0]       mem_addr, mem_wdata, res_rdata;
    logic [3:0]        mem_be, mem_id;
    fir_xifu_ex2wb_t   ex2wb;
    fir_xifu_ex2ctrl_t ex2ctrl;

    always #5 clk = ~clk;

    fir_xifu_ex dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .id2ex_i                (id2ex),
        .id2ex_valid_i          (id2ex_valid),
        .ex_ready_o             (ex_ready),
        .ctrl2ex_i              (ctrl2ex),
        .xif_mem_valid_o        (mem_valid),
        .xif_mem_ready_i        (mem_ready),
        .xif_mem_addr_o         (mem_addr),
        .xif_mem_we_o           (mem_we),
        .xif_mem_be_o           (mem_be),
        .xif_mem_wdata_o        (mem_wdata),
        .xif_mem_id_o           (mem_id),
        .xif_mem_result_valid_i (res_valid),
        .xif_mem_result_rdata_i (res_rdata),
        .ex2wb_o                (ex2wb),
        .ex2ctrl_o              (ex2ctrl)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] id; } mreq_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;
    typedef struct { logic mis; logic [3:0] id; } done_t;

    mreq_t       mq[$];
    wb_t         wq[$];
    done_t       dq[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] resp_mem [logic [31:0]];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fix_rdy = -1;
    bit   hold_res = 1'b0;
    logic [3:0] next_id = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_dflt(a);
    endfunction

    function automatic logic [31:0] ref_dotp(input logic [31:0] x1, input logic [31:0] x2,
                                             input logic [31:0] xd);
        longint s;
        s = longint'($signed(xd))
          + longint'($signed(x1[15:0])) * longint'($signed(x2[15:0]))
          + longint'($signed(x1[31:16])) * longint'($signed(x2[31:16]));
`ifdef FIR_XIFU_DOTP_SAT_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Issue one instruction, wait for acceptance, then record what the spec predicts
    task automatic issue(input fir_xifu_instr_e ins, input logic [31:0] base, input logic [11:0] off,
                         input logic [4:0] rd, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] xd);
        logic signed [31:0] soff;
        logic [31:0] a;
        int n;
        mreq_t m;
        wb_t   w;
        done_t d;
        id2ex.instr  = ins;
        id2ex.base   = base;
        id2ex.offset = off;
        id2ex.rs1    = 5'($urandom);
        id2ex.rs2    = 5'($urandom);
        id2ex.rd     = rd;
        id2ex.id     = next_id;
        ctrl2ex.xrs1_data = x1;
        ctrl2ex.xrs2_data = x2;
        ctrl2ex.xrd_data  = xd;
        id2ex_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 200), 64'd1);
        soff = $signed(off);
        a    = base + soff;
        d.mis = 1'b0;
        d.id  = next_id;
        if (n < 200) begin
            case (ins)
                INSTR_XFIRLW, INSTR_XFIRSW: begin
                    if (a[1:0] != 2'b00) begin
                        d.mis = 1'b1;
                        dq.push_back(d);
                    end else begin
                        m.addr = a;
                        m.id   = next_id;
                        m.we   = (ins == INSTR_XFIRSW);
                        m.wdata = (ins == INSTR_XFIRSW) ? x2 : 32'h0;
                        mq.push_back(m);
                        if (ins == INSTR_XFIRLW) begin
                            w.rd = rd; w.data = ref_rd(a); w.cyc = -1;
                            wq.push_back(w);
                        end else begin
                            ref_mem[a] = x2;
                        end
                        dq.push_back(d);
                    end
                end
                INSTR_XFIRDOTP: begin
                    w.rd = rd; w.data = ref_dotp(x1, x2, xd); w.cyc = cyc + 1;
                    wq.push_back(w);
                    dq.push_back(d);
                end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        id2ex_valid = 1'b0;
        next_id     = next_id + 4'd1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (((mq.size() + wq.size() + dq.size()) != 0 || !ex_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", 64'(n < 300), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"},     64'(ex_ready),  64'd1);
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_mem_ctl"},   64'({mem_we, mem_be, mem_id}), 64'd0);
        chk({tag, "_ex2wb"},     64'(ex2wb),     64'd0);
        chk({tag, "_ex2ctrl"},   64'(ex2ctrl),   64'd0);
    endtask

    // Memory responder: random ready/result delays, occasional early result in REQ
    initial begin : responder
        bit          pend, loaded;
        int          rdy_cnt, res_cnt;
        logic [31:0] pend_data;
        pend = 0; loaded = 0; rdy_cnt = 0; res_cnt = 0; pend_data = 0;
        mem_ready = 1'b0; res_valid = 1'b0; res_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            res_valid = 1'b0;
            res_rdata = $urandom;
            if (!rst_n) begin
                pend = 0; loaded = 0;
            end else if (pend) begin
                if (!hold_res) begin
                    if (res_cnt == 0) begin
                        res_valid = 1'b1;
                        res_rdata = pend_data;
                        pend      = 0;
                    end else begin
                        res_cnt--;
                    end
                end
            end else if (mem_valid) begin
                if (!loaded) begin
                    rdy_cnt = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
                    loaded  = 1;
                end
                if (rdy_cnt == 0) begin
                    mem_ready = 1'b1;
                    loaded    = 0;
                    pend      = 1;
                    res_cnt   = $urandom_range(0, 3);
                    if (mem_we) begin
                        resp_mem[mem_addr] = mem_wdata;
                        pend_data = 32'h0;
                    end else begin
                        pend_data = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : mem_dflt(mem_addr);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        res_valid = 1'b1;
                        res_rdata = ~pend_data;
                    end
                end else begin
                    rdy_cnt--;
                end
            end
        end
    end

    // Monitor: compare every DUT output event against the head of its queue
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_valid) begin
                    chk("ready_low_in_req", 64'(ex_ready), 64'd0);
                    chk("mreq_expected", 64'(mq.size() != 0), 64'd1);
                    if (mq.size() != 0) begin
                        chk("mem_addr",  64'(mem_addr),  64'(mq[0].addr));
                        chk("mem_we",    64'(mem_we),    64'(mq[0].we));
                        chk("mem_wdata", 64'(mem_wdata), 64'(mq[0].wdata));
                        chk("mem_be",    64'(mem_be),    64'h0F);
                        chk("mem_id",    64'(mem_id),    64'(mq[0].id));
                        if (mem_ready) void'(mq.pop_front());
                    end
                end
                if (ex2wb.we) begin
                    chk("wb_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        chk("wb_rd",   64'(ex2wb.rd),   64'(wq[0].rd));
                        chk("wb_data", 64'(ex2wb.data), 64'(wq[0].data));
                        if (wq[0].cyc >= 0) chk("dotp_latency", 64'(cyc), 64'(wq[0].cyc));
                        void'(wq.pop_front());
                    end
                end
                if (ex2ctrl.done) begin
                    chk("done_expected", 64'(dq.size() != 0), 64'd1);
                    if (dq.size() != 0) begin
                        chk("done_misaligned", 64'(ex2ctrl.misaligned), 64'(dq[0].mis));
                        chk("done_id",         64'(ex2ctrl.id),         64'(dq[0].id));
                        void'(dq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int sel;
        int offv;
        logic [31:0] base, x1, x2;
        fir_xifu_instr_e ins;
        rst_n = 1'b0; id2ex = '0; ctrl2ex = '0; id2ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors
        issue(INSTR_XFIRDOTP, 32'h0, 12'h0, 5'd7, 32'h0003_FFFE, 32'h0002_0005, 32'd10);
        wait_idle();
        ref_mem[32'h0FFC] = 32'hCAFE_BABE;
        resp_mem[32'h0FFC] = 32'hCAFE_BABE;
        fix_rdy = 3;
        issue(INSTR_XFIRLW, 32'h1000, 12'hFFC, 5'd3, 32'h1, 32'h2, 32'h3);
        wait_idle();
        fix_rdy = -1;
        issue(INSTR_XFIRSW, 32'h2000, 12'd8, 5'd0, 32'h0, 32'h1234_5678, 32'h0);
        wait_idle();
        issue(INSTR_XFIRLW, 32'h1001, 12'h0, 5'd4, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis_ready_stays", 64'(ex_ready), 64'd1);
        chk("mis_no_mem",      64'(mem_valid), 64'd0);
        wait_idle();
        issue(INSTR_XFIRDOTP, 32'h0, 12'h0, 5'd9, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF);
        issue(INSTR_INVALID, 32'h0, 12'h0, 5'd1, 32'h0, 32'h0, 32'h0);
        wait_idle();

        // Reset while the load waits in RESP
        hold_res = 1'b1;
        issue(INSTR_XFIRLW, 32'h3000, 12'h0, 5'd2, 32'h0, 32'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (!(ex2ctrl.busy && !mem_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_resp", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("mid_reset");
        mq.delete(); wq.delete(); dq.delete();
        hold_res = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic, often back-to-back so id2ex_valid stays high while busy
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            ins = (sel < 3) ? INSTR_XFIRLW : (sel < 6) ? INSTR_XFIRSW :
                  (sel < 9) ? INSTR_XFIRDOTP : INSTR_INVALID;
            base = 32'h4000 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) base = base + $urandom_range(1, 3);
            offv = int'($urandom_range(0, 16)) * 4 - 32;
            x1 = $urandom;
            x2 = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                x1 = 32'h8000_8000;
                x2 = 32'h8000_8000;
            end
            issue(ins, base, offv[11:0], 5'($urandom), x1, x2, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("queues_empty", 64'(mq.size() + wq.size() + dq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
